// File: rtl/robot_pkg.sv
// Shared types and constants for the robot navigation controller.
// State encoding and direction codes are visible on the top-level ports.
package robot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    SLOW = 3'd2,
    STOP = 3'd3,
    TURN = 3'd4
  } state_e;

  localparam logic [1:0] DIR_HALT  = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Width of a counter that must hold 0..max(a,b)-1; never narrower than 1 bit.
  function automatic int cnt_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 3) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/robot_min_sel.sv
// Combinational unsigned minimum across N_SENS packed distance channels.
module robot_min_sel #(
  parameter int N_SENS = 3,
  parameter int DIST_W = 16
) (
  input  logic [N_SENS*DIST_W-1:0] dist_v,
  output logic [DIST_W-1:0]        min_d
);

  // NOTE: always_comb uses blocking assignments so each loop step sees the
  // running minimum from the previous one; the first assignment is the default.
  always_comb begin
    min_d = dist_v[DIST_W-1:0];
    for (int i = 1; i < N_SENS; i++) begin
      if (dist_v[i*DIST_W +: DIST_W] < min_d) min_d = dist_v[i*DIST_W +: DIST_W];
    end
  end

endmodule

// File: rtl/robot_nav_ctrl.sv
// Nearest-obstacle speed/direction controller with hysteresis, timed stop and turn.
// Optional sensor-silence watchdog is enabled with the ROBOT_WDT_EN macro.
module robot_nav_ctrl
  import robot_pkg::*;
#(
  parameter int N_SENS   = 3,
  parameter int DIST_W   = 16,
  parameter int STOP_TH  = 100,
  parameter int SLOW_TH  = 300,
  parameter int HYST     = 20,
  parameter int STOP_CYC = 8,
  parameter int TURN_CYC = 50,
  parameter int SPD_W    = 8,
  parameter int SPD_FAST = 200,
  parameter int SPD_SLOW = 80,
  parameter int WDT_CYC  = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SENS*DIST_W-1:0] dist_v,
  input  logic                     dist_valid,
  input  logic                     en,
  output logic [SPD_W-1:0]         speed,
  output logic [1:0]               dir,
  output logic [2:0]               state,
  output logic                     wdt_trip
);

  localparam int CNT_W = cnt_width(STOP_CYC, TURN_CYC);
  localparam int CMP_W = DIST_W + 1;

  // One extra bit so threshold-plus-hysteresis never wraps.
  localparam logic [CMP_W-1:0] STOP_LIM  = CMP_W'(STOP_TH);
  localparam logic [CMP_W-1:0] SLOW_LIM  = CMP_W'(SLOW_TH);
  localparam logic [CMP_W-1:0] SLOW_REL  = CMP_W'(SLOW_TH + HYST);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);

  logic [DIST_W-1:0] min_d, min_q;
  logic [CMP_W-1:0]  min_ext;
  logic              side_q, have_sample;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              turn_left_q, turn_left_d;
  logic              wdt_fire, hold_stop;

  robot_min_sel #(.N_SENS(N_SENS), .DIST_W(DIST_W)) u_min_sel (
    .dist_v (dist_v),
    .min_d  (min_d)
  );

  assign min_ext = {1'b0, min_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q       <= '0;
      side_q      <= 1'b0;
      have_sample <= 1'b0;
    end else if (dist_valid) begin
      min_q       <= min_d;
      side_q      <= dist_v[DIST_W-1:0] > dist_v[(N_SENS-1)*DIST_W +: DIST_W];
      have_sample <= 1'b1;
    end
  end

`ifdef ROBOT_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_LIM = WDT_W'(WDT_CYC);

  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_trip_q;

  assign wdt_fire  = (wdt_cnt_q == WDT_LIM) && (state_q != IDLE);
  assign hold_stop = wdt_trip_q;
  assign wdt_trip  = wdt_trip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q  <= '0;
      wdt_trip_q <= 1'b0;
    end else begin
      if (dist_valid || state_q == IDLE) wdt_cnt_q <= '0;
      else if (wdt_cnt_q != WDT_LIM)     wdt_cnt_q <= wdt_cnt_q + 1'b1;
      if (!en)           wdt_trip_q <= 1'b0;
      else if (wdt_fire) wdt_trip_q <= 1'b1;
    end
  end
`else
  assign wdt_fire  = 1'b0;
  assign hold_stop = 1'b0;
  assign wdt_trip  = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    turn_left_d = turn_left_q;
    cnt_d       = '0;
    unique case (state_q)
      IDLE: if (en && have_sample) state_d = FWD;
      FWD: begin
        if (min_ext < STOP_LIM)      state_d = STOP;
        else if (min_ext < SLOW_LIM) state_d = SLOW;
      end
      SLOW: begin
        if (min_ext < STOP_LIM)       state_d = STOP;
        else if (min_ext >= SLOW_REL) state_d = FWD;
      end
      STOP: begin
        if (cnt_q != STOP_LAST) cnt_d = cnt_q + 1'b1;
        else if (hold_stop)     cnt_d = cnt_q;
        else begin
          state_d     = TURN;
          turn_left_d = side_q;
        end
      end
      TURN: begin
        if (cnt_q != TURN_LAST) cnt_d = cnt_q + 1'b1;
        else                    state_d = SLOW;
      end
      default: state_d = IDLE;
    endcase
    if (wdt_fire) state_d = STOP;
    if (!en && state_q != IDLE) state_d = IDLE;
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      turn_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      turn_left_q <= turn_left_d;
    end
  end

  always_comb begin
    speed = '0;
    dir   = DIR_HALT;
    unique case (state_q)
      FWD:  begin speed = SPD_W'(SPD_FAST); dir = DIR_FWD; end
      SLOW: begin speed = SPD_W'(SPD_SLOW); dir = DIR_FWD; end
      TURN: begin speed = SPD_W'(SPD_SLOW); dir = turn_left_q ? DIR_LEFT : DIR_RIGHT; end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_robot_nav_ctrl.sv
// Self-checking bench for robot_nav_ctrl: vector table, corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_robot_nav_ctrl;

  localparam int DIST_W = 16;
  localparam int STOP_TH = 100, SLOW_TH = 300, HYST = 20;
  localparam int STOP_CYC = 8, TURN_CYC = 50;
  localparam int M_IDLE = 0, M_FWD = 1, M_SLOW = 2, M_STOP = 3, M_TURN = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3*DIST_W-1:0] dist_v = '0;
  logic              dist_valid = 1'b0;
  logic              en = 1'b0;
  logic [7:0]        speed;
  logic [1:0]        dir;
  logic [2:0]        state;
  logic              wdt_trip;

  robot_nav_ctrl #(.WDT_CYC(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .dist_v     (dist_v),
    .dist_valid (dist_valid),
    .en         (en),
    .speed      (speed),
    .dir        (dir),
    .state      (state),
    .wdt_trip   (wdt_trip)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge with the given inputs; outputs are settled on return.
  task automatic step(input bit r, input bit e, input bit v, input int c0, input int c1, input int c2);
    @(negedge clk);
    rst        = r;
    en         = e;
    dist_valid = v;
    dist_v     = {DIST_W'(c2), DIST_W'(c1), DIST_W'(c0)};
    @(posedge clk);
    #1;
  endtask

  // Idle edges (en=1) while the DUT stays in state st; n = edges taken.
  task automatic run_while(input int st, input int limit, output int n);
    n = 0;
    while (int'(state) == st && n < limit) begin
      step(0, 1, 0, 0, 0, 0);
      n++;
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_time, m_min;
  bit m_side, m_have, m_tl;

  function automatic void model_edge(bit r, bit e, bit v, int c0, int c1, int c2);
    int nxt;
    if (r) begin
      m_state = M_IDLE; m_time = 0; m_min = 0;
      m_side = 0; m_have = 0; m_tl = 0;
      return;
    end
    nxt = m_state;
    if (m_state != M_IDLE && !e) nxt = M_IDLE;
    else case (m_state)
      M_IDLE: if (e && m_have) nxt = M_FWD;
      M_FWD:  if (m_min < STOP_TH) nxt = M_STOP; else if (m_min < SLOW_TH) nxt = M_SLOW;
      M_SLOW: if (m_min < STOP_TH) nxt = M_STOP; else if (m_min >= SLOW_TH + HYST) nxt = M_FWD;
      M_STOP: if (m_time + 1 == STOP_CYC) begin nxt = M_TURN; m_tl = m_side; end
      M_TURN: if (m_time + 1 == TURN_CYC) nxt = M_SLOW;
      default: nxt = M_IDLE;
    endcase
    m_time  = (nxt == m_state) ? m_time + 1 : 0;
    m_state = nxt;
    if (v) begin
      m_min  = c0;
      if (c1 < m_min) m_min = c1;
      if (c2 < m_min) m_min = c2;
      m_side = c0 > c2;
      m_have = 1;
    end
  endfunction

  function automatic int exp_speed(int s);
    case (s)
      M_FWD: return 200;
      M_SLOW, M_TURN: return 80;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_dir(int s, bit tl);
    case (s)
      M_FWD, M_SLOW: return 1;
      M_TURN: return tl ? 2 : 3;
      default: return 0;
    endcase
  endfunction

  int interesting [10] = '{0, 99, 100, 101, 250, 299, 300, 319, 320, 321};

  function automatic int pick_dist();
    if ($urandom_range(0, 1) == 0) return interesting[$urandom_range(0, 9)];
    return $urandom_range(0, 600);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit rst; bit en; bit dv;
    int c0; int c1; int c2;
    int st; int spd; int dr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n;
    int gap;

    tbl[0]  = '{1, 0, 0,   0,   0,   0, 0,   0, 0};
    tbl[1]  = '{0, 1, 0,   0,   0,   0, 0,   0, 0};
    tbl[2]  = '{0, 1, 0,   0,   0,   0, 0,   0, 0};
    tbl[3]  = '{0, 1, 1, 500, 500, 500, 0,   0, 0};
    tbl[4]  = '{0, 1, 0,   0,   0,   0, 1, 200, 1};
    tbl[5]  = '{0, 1, 1, 500, 250, 500, 1, 200, 1};
    tbl[6]  = '{0, 1, 0,   0,   0,   0, 2,  80, 1};
    tbl[7]  = '{0, 1, 1, 310, 400, 500, 2,  80, 1};
    tbl[8]  = '{0, 1, 0,   0,   0,   0, 2,  80, 1};
    tbl[9]  = '{0, 1, 1, 320, 500, 500, 2,  80, 1};
    tbl[10] = '{0, 1, 0,   0,   0,   0, 1, 200, 1};
    tbl[11] = '{0, 1, 1, 400, 100, 150, 1, 200, 1};
    tbl[12] = '{0, 1, 0,   0,   0,   0, 2,  80, 1};
    tbl[13] = '{0, 1, 0,   0,   0,   0, 2,  80, 1};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].dv, tbl[i].c0, tbl[i].c1, tbl[i].c2);
      check($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
      check($sformatf("tbl%0d.speed", i), int'(speed), tbl[i].spd);
      check($sformatf("tbl%0d.dir", i),   int'(dir),   tbl[i].dr);
      check($sformatf("tbl%0d.wdt", i),   int'(wdt_trip), 0);
    end

    // Obstacle on the middle channel, left clearer: 8 cycles STOP, 50 TURN left.
    step(0, 1, 1, 400, 90, 150);
    check("obst.latency", int'(state), M_SLOW);
    step(0, 1, 0, 0, 0, 0);
    check("obst.stop", int'(state), M_STOP);
    check("obst.stop_spd", int'(speed), 0);
    run_while(M_STOP, 40, n);
    check("obst.stop_len", n, STOP_CYC);
    check("obst.turn", int'(state), M_TURN);
    check("obst.turn_dir", int'(dir), 2);
    check("obst.turn_spd", int'(speed), 80);
    run_while(M_TURN, 100, n);
    check("obst.turn_len", n, TURN_CYC);
    check("obst.slow", int'(state), M_SLOW);
    step(0, 1, 0, 0, 0, 0);
    check("obst.restop", int'(state), M_STOP);

    // Tie between outer channels steers right; sample mid-STOP keeps the timer.
    step(0, 1, 1, 200, 50, 200);
    run_while(M_STOP, 40, n);
    check("tie.stop_len", n + 1, STOP_CYC);
    check("tie.turn", int'(state), M_TURN);
    check("tie.dir", int'(dir), 3);

    // en=0 mid-turn returns to IDLE at once; sample is kept.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("en0.state", int'(state), M_IDLE);
    check("en0.speed", int'(speed), 0);
    step(0, 1, 0, 0, 0, 0);
    check("en1.fwd", int'(state), M_FWD);
    step(0, 1, 0, 0, 0, 0);
    check("en1.stop", int'(state), M_STOP);
    run_while(M_STOP, 40, n);
    step(0, 1, 0, 0, 0, 0);
    check("rst.pre_turn", int'(state), M_TURN);

    // rst mid-turn clears have_sample: IDLE until a fresh sample.
    step(1, 1, 0, 0, 0, 0);
    check("rst.state", int'(state), M_IDLE);
    check("rst.dir", int'(dir), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    check("rst.hold_idle", int'(state), M_IDLE);
    step(0, 1, 1, 500, 500, 500);
    check("rst.sample_edge", int'(state), M_IDLE);
    step(0, 1, 0, 0, 0, 0);
    check("rst.fwd", int'(state), M_FWD);

`ifdef ROBOT_WDT_EN
    // Sensor silence in FWD trips the watchdog and pins the robot in STOP.
    run_while(M_FWD, 40, n);
    check("wdt.fires", int'(state), M_STOP);
    check("wdt.fwd_window", int'(n >= 19 && n <= 23), 1);
    step(0, 1, 0, 0, 0, 0);
    check("wdt.trip", int'(wdt_trip), 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
    check("wdt.held", int'(state), M_STOP);
    check("wdt.held_trip", int'(wdt_trip), 1);
    step(0, 0, 0, 0, 0, 0);
    check("wdt.en0_state", int'(state), M_IDLE);
    check("wdt.en0_clear", int'(wdt_trip), 0);
`endif

    // Randomized traffic; samples at most 10 cycles apart so the watchdog stays quiet.
    step(1, 0, 0, 0, 0, 0);
    model_edge(1, 0, 0, 0, 0, 0);
    gap = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, e, v;
      int c0, c1, c2;
      r  = ($urandom_range(0, 499) == 0);
      e  = ($urandom_range(0, 99) >= 2);
      v  = (gap >= 9) || ($urandom_range(0, 3) == 0);
      gap = v ? 0 : gap + 1;
      c0 = pick_dist(); c1 = pick_dist(); c2 = pick_dist();
      step(r, e, v, c0, c1, c2);
      model_edge(r, e, v, c0, c1, c2);
      if (int'(state) != m_state || int'(speed) != exp_speed(m_state) ||
          int'(dir) != exp_dir(m_state, m_tl) || wdt_trip != 1'b0) begin
        check($sformatf("rnd%0d.state", i), int'(state), m_state);
        check($sformatf("rnd%0d.speed", i), int'(speed), exp_speed(m_state));
        check($sformatf("rnd%0d.dir", i), int'(dir), exp_dir(m_state, m_tl));
        check($sformatf("rnd%0d.wdt", i), int'(wdt_trip), 0);
      end else begin
        n_vec++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
